// File: rtl/ecall_ctrl.sv
// ecall_ctrl: services RV32I environment calls for the single-cycle core.
// Print calls (a7 = 1/11/34) retire in zero extra cycles by latching the
// display registers. Read-int (a7 = 5) stalls the core until a debounced,
// freshly pressed confirm button, then writes the switch value to x10.
// Exit (a7 = 10) stalls the core permanently.
//
// Handshake: while stall=1 the core holds the ecall instruction, so
// ecall_req/a7_val/a0_val stay stable. The call retires on the first rising
// edge where stall=0. wb_en and the PC advance share that edge.
module ecall_ctrl #(
  parameter int SW_W       = 16,
  parameter int DEB_CYCLES = 4,
  parameter bit SIGN_EXT   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ecall_req,
  input  logic [31:0]     a7_val,
  input  logic [31:0]     a0_val,
  input  logic [SW_W-1:0] sw_in,
  input  logic            confirm_btn,
  output logic            stall,
  output logic            wb_en,
  output logic [31:0]     wb_data,
  output logic [31:0]     disp_data,
  output logic [1:0]      disp_mode,
  output logic            wait_led,
  output logic            halted,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_IN = 2'd1,
    S_WB      = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam int              CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
  localparam logic [31:0] SVC_READ_INT   = 32'd5;
  localparam logic [31:0] SVC_EXIT       = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SVC_PRINT_HEX  = 32'd34;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] deb_cnt;
  logic             armed;
  logic             is_call;
  logic             press_done;
  logic [31:0]      sw_ext;

  // A new call is only accepted from IDLE; requests in WB/HALT are ignored.
  assign is_call    = (state == S_IDLE) && ecall_req;
  // Final debounced cycle of a fresh press.
  assign press_done = (state == S_WAIT_IN) && armed && confirm_btn && (deb_cnt == CNT_LAST);
  assign sw_ext     = SIGN_EXT ? 32'($signed(sw_in)) : 32'(sw_in);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (is_call && a7_val == SVC_READ_INT) state_nxt = S_WAIT_IN;
        else if (is_call && a7_val == SVC_EXIT) state_nxt = S_HALT;
      end
      S_WAIT_IN: if (press_done) state_nxt = S_WB;
      S_WB:      state_nxt = S_IDLE;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; stall also looks at the incoming call in IDLE.
  always_comb begin
    stall     = 1'b0;
    wb_en     = 1'b0;
    wait_led  = 1'b0;
    halted    = 1'b0;
    state_dbg = state;
    unique case (state)
      S_IDLE:    stall = is_call && (a7_val == SVC_READ_INT || a7_val == SVC_EXIT);
      S_WAIT_IN: begin
        stall    = 1'b1;
        wait_led = 1'b1;
      end
      S_WB:      wb_en = 1'b1;
      S_HALT: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default:   stall = 1'b0;
    endcase
  end

  // Display latch, debounce counter, arming and read result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_data <= 32'd0;
      disp_mode <= 2'd0;
      wb_data   <= 32'd0;
      deb_cnt   <= '0;
      armed     <= 1'b0;
    end else begin
      if (is_call) begin
        unique case (a7_val)
          SVC_PRINT_INT: begin
            disp_data <= a0_val;
            disp_mode <= 2'd1;
          end
          SVC_PRINT_CHAR: begin
            disp_data <= {24'd0, a0_val[7:0]};
            disp_mode <= 2'd2;
          end
          SVC_PRINT_HEX: begin
            disp_data <= a0_val;
            disp_mode <= 2'd3;
          end
          SVC_READ_INT: begin
            deb_cnt <= '0;
            armed   <= 1'b0;
          end
          default: ;
        endcase
      end
      if (state == S_WAIT_IN) begin
        // A low sample arms the read so a button held over from a previous
        // read cannot confirm this one.
        if (!confirm_btn) begin
          armed   <= 1'b1;
          deb_cnt <= '0;
        end else if (armed) begin
          if (deb_cnt == CNT_LAST) wb_data <= sw_ext;
          else                     deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ecall_ctrl.sv
// Testbench for ecall_ctrl: directed scenarios plus randomized call streams
// checked against a transaction-level model of the ecall services.
module tb_ecall_ctrl;

  localparam int SW_W = 16;
  localparam int DEB  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            ecall_req;
  logic [31:0]     a7_val;
  logic [31:0]     a0_val;
  logic [SW_W-1:0] sw_in;
  logic            confirm_btn;
  logic            stall;
  logic            wb_en;
  logic [31:0]     wb_data;
  logic [31:0]     disp_data;
  logic [1:0]      disp_mode;
  logic            wait_led;
  logic            halted;
  logic [1:0]      state_dbg;

  always #5 clk = ~clk;

  ecall_ctrl #(.SW_W(SW_W), .DEB_CYCLES(DEB), .SIGN_EXT(1'b1)) dut (
    .clk(clk), .rst(rst), .ecall_req(ecall_req), .a7_val(a7_val), .a0_val(a0_val),
    .sw_in(sw_in), .confirm_btn(confirm_btn), .stall(stall), .wb_en(wb_en),
    .wb_data(wb_data), .disp_data(disp_data), .disp_mode(disp_mode),
    .wait_led(wait_led), .halted(halted), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_disp;
  logic [1:0]  exp_mode;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Read-int result: switch value sign-extended to 32 bits.
  function automatic logic [31:0] model_ext(input logic [SW_W-1:0] sw);
    int v;
    v = int'(sw);
    if (v >= (1 << (SW_W - 1))) v = v - (1 << SW_W);
    return 32'(v);
  endfunction

  // Index of the button sample on which the read is accepted: the first
  // run of DEB consecutive highs that directly follows a low sample.
  function automatic int fire_idx(input int b[$]);
    bit ok;
    for (int i = DEB; i < b.size(); i++) begin
      ok = (b[i-DEB] == 0);
      for (int k = i - DEB + 1; k <= i; k++) if (b[k] != 1) ok = 1'b0;
      if (ok) return i;
    end
    return -1;
  endfunction

  task automatic check_disp(input string tag);
    check({tag, "_disp"}, disp_data, exp_disp);
    check({tag, "_mode"}, 32'(disp_mode), 32'(exp_mode));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_wb_en"}, 32'(wb_en), 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
    check({tag, "_wait"}, 32'(wait_led), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check_disp(tag);
  endtask

  // ---------------- driver tasks ----------------
  // Print-type or no-op call: never stalls; display follows the service rules.
  task automatic do_call(input logic [31:0] a7, input logic [31:0] a0);
    ecall_req = 1'b1; a7_val = a7; a0_val = a0;
    #1;
    check("call_stall", 32'(stall), 32'd0);
    cyc();
    ecall_req = 1'b0;
    if (a7 == 32'd1)       begin exp_disp = a0; exp_mode = 2'd1; end
    else if (a7 == 32'd11) begin exp_disp = a0 & 32'hFF; exp_mode = 2'd2; end
    else if (a7 == 32'd34) begin exp_disp = a0; exp_mode = 2'd3; end
    #1;
    check_disp("call");
    check("call_wb_en", 32'(wb_en), 32'd0);
    check("call_stall_after", 32'(stall), 32'd0);
  endtask

  // Read-int call with a given per-cycle button pattern while waiting.
  task automatic do_read(input logic [SW_W-1:0] sw, input int btn[$]);
    int f;
    f = fire_idx(btn);
    if (f < 0) begin
      check("read_pattern_fires", 32'd0, 32'd1);
      return;
    end
    exp_q.push_back(model_ext(sw));
    sw_in = sw; ecall_req = 1'b1; a7_val = 32'd5; a0_val = $urandom;
    confirm_btn = 1'($urandom_range(0, 1));
    #1;
    check("read_entry_stall", 32'(stall), 32'd1);
    cyc();
    ecall_req = 1'b0;
    for (int i = 0; i <= f; i++) begin
      confirm_btn = btn[i][0];
      #1;
      check("read_wait_stall", 32'(stall), 32'd1);
      check("read_wait_led", 32'(wait_led), 32'd1);
      check("read_wait_wb_en", 32'(wb_en), 32'd0);
      cyc();
    end
    // Writeback cycle; a concurrent request belongs to the retiring ecall.
    ecall_req = 1'b1; a7_val = 32'd1; a0_val = $urandom;
    confirm_btn = 1'($urandom_range(0, 1)); sw_in = SW_W'($urandom);
    #1;
    check("read_wb_en", 32'(wb_en), 32'd1);
    check("read_wb_stall", 32'(stall), 32'd0);
    check("read_wb_wait", 32'(wait_led), 32'd0);
    check("read_wb_data", wb_data, exp_q.pop_front());
    cyc();
    ecall_req = 1'b0;
    #1;
    check("read_after_wb_en", 32'(wb_en), 32'd0);
    check("read_after_stall", 32'(stall), 32'd0);
    check_disp("read_after");
  endtask

  task automatic do_reset_async();
    rst = 1'b0;
    exp_disp = 32'd0; exp_mode = 2'd0;
    #1;
    ecall_req = 1'b0;
    #1;
    check_all_zero("reset");
    cyc();
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          pat[$];
    int          len;
    int          op;
    logic [31:0] a7;

    rst = 1'b0; ecall_req = 1'b0; a7_val = '0; a0_val = '0; sw_in = '0; confirm_btn = 1'b0;
    exp_disp = 32'd0; exp_mode = 2'd0;
    #12;
    check_all_zero("por");
    cyc();
    rst = 1'b1;
    cyc();

    // print int of a negative value
    do_call(32'd1, 32'hFFFF_FFF6);
    // basic read: low 1 cycle then high DEB cycles
    pat = '{0, 1, 1, 1, 1};
    do_read(16'h8001, pat);
    // button already held on entry must not confirm
    pat = '{};
    for (int i = 0; i < 10; i++) pat.push_back(1);
    pat.push_back(0);
    for (int i = 0; i < DEB; i++) pat.push_back(1);
    do_read(16'h1234, pat);
    // glitch in the middle of a press restarts the count
    pat = '{0, 1, 1, 1, 0, 1, 1, 1, 1};
    do_read(16'h7FFF, pat);
    // char and hex prints, unknown service
    do_call(32'd11, 32'hABCD_EF41);
    do_call(32'd34, 32'hDEAD_BEEF);
    do_call(32'd99, 32'h1111_2222);

    // reset while waiting for input: no writeback afterwards
    sw_in = 16'h00AA; ecall_req = 1'b1; a7_val = 32'd5;
    cyc();
    ecall_req = 1'b0;
    confirm_btn = 1'b0; cyc();
    confirm_btn = 1'b1; cyc();
    do_reset_async();
    for (int i = 0; i < DEB + 2; i++) begin
      #1;
      check("post_reset_wb_en", 32'(wb_en), 32'd0);
      check("post_reset_stall", 32'(stall), 32'd0);
      cyc();
    end
    confirm_btn = 1'b0;
    do_call(32'd99, 32'h5);

    // randomized call stream
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        case ($urandom_range(0, 2))
          0:       a7 = 32'd1;
          1:       a7 = 32'd11;
          default: a7 = 32'd34;
        endcase
        do_call(a7, $urandom);
      end else if (op < 6) begin
        do begin
          a7 = (op == 4) ? 32'($urandom_range(0, 40)) : $urandom;
        end while (a7 == 32'd1 || a7 == 32'd5 || a7 == 32'd10 || a7 == 32'd11 || a7 == 32'd34);
        do_call(a7, $urandom);
      end else if (op < 9) begin
        pat = '{};
        len = $urandom_range(0, 12);
        for (int i = 0; i < len; i++) pat.push_back(($urandom_range(0, 3) != 0) ? 1 : 0);
        pat.push_back(0);
        for (int i = 0; i < DEB; i++) pat.push_back(1);
        do_read(SW_W'($urandom), pat);
      end else begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) begin
          #1;
          check("idle_stall", 32'(stall), 32'd0);
          cyc();
        end
      end
    end

    // exit: halts permanently, later calls change nothing
    ecall_req = 1'b1; a7_val = 32'd10; a0_val = $urandom;
    #1;
    check("exit_stall", 32'(stall), 32'd1);
    cyc();
    for (int i = 0; i < 6; i++) begin
      ecall_req = 1'($urandom_range(0, 1)); a7_val = 32'd1; a0_val = $urandom;
      confirm_btn = 1'($urandom_range(0, 1));
      #1;
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_stall", 32'(stall), 32'd1);
      check("halt_wb_en", 32'(wb_en), 32'd0);
      check_disp("halt");
      cyc();
    end
    do_reset_async();
    do_call(32'd1, 32'h0000_0042);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
